// File: rtl/alu_result_collector.sv
// alu_result_collector: packs a stream of 1-bit ALU results into WIDTH-bit words.
// Bits fill from bit 0 upward; a word is emitted when full or on flush of a
// partial word. Optional build macro ALU_COLLECT_PARITY_EN adds an even-parity
// output registered alongside the word.
module alu_result_collector #(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned CW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    out_count
`ifdef ALU_COLLECT_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] sh, sh_n;
    logic [WIDTH-1:0] data_n;
    logic [CW-1:0]    count_n;
    logic             valid_n;
    logic             ready_n;
    logic             in_xfer_c;
    logic [WIDTH-1:0] fill_sh_c;
    logic [CW-1:0]    fill_cnt_c;
`ifdef ALU_COLLECT_PARITY_EN
    logic             parity_n;
`endif

    // State and output registers; reset discards any partially collected word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= COLLECT;
            cnt       <= '0;
            sh        <= '0;
            out_data  <= '0;
            out_count <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
`ifdef ALU_COLLECT_PARITY_EN
            out_parity <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            sh        <= sh_n;
            out_data  <= data_n;
            out_count <= count_n;
            out_valid <= valid_n;
            in_ready  <= ready_n;
`ifdef ALU_COLLECT_PARITY_EN
            out_parity <= parity_n;
`endif
        end
    end

    // Next-state logic: accept bits, decide on word emission, release on handshake.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        sh_n       = sh;
        data_n     = out_data;
        count_n    = out_count;
        valid_n    = out_valid;
        ready_n    = in_ready;
`ifdef ALU_COLLECT_PARITY_EN
        parity_n   = out_parity;
`endif
        in_xfer_c  = in_valid && in_ready;
        fill_sh_c  = sh;
        fill_cnt_c = cnt;

        case (state)
            COLLECT: begin
                // Same-cycle input is folded in before the flush/full decision.
                if (in_xfer_c) begin
                    fill_sh_c  = sh | (WIDTH'(in_bit) << cnt);
                    fill_cnt_c = CW'(cnt + CW'(1));
                end
                sh_n  = fill_sh_c;
                cnt_n = fill_cnt_c;
                if ((fill_cnt_c == CW'(WIDTH)) || (flush && (fill_cnt_c != '0))) begin
                    state_n = HOLD;
                    data_n  = fill_sh_c;
                    count_n = fill_cnt_c;
                    valid_n = 1'b1;
                    ready_n = 1'b0;
`ifdef ALU_COLLECT_PARITY_EN
                    parity_n = ^fill_sh_c;
`endif
                end
            end
            HOLD: begin
                // Word is held stable; flush here is dropped, not remembered.
                if (out_ready) begin
                    state_n = COLLECT;
                    cnt_n   = '0;
                    sh_n    = '0;
                    valid_n = 1'b0;
                    ready_n = 1'b1;
                end
            end
            default: begin
                state_n = COLLECT;
                cnt_n   = '0;
                sh_n    = '0;
                valid_n = 1'b0;
                ready_n = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_result_collector.sv
// Testbench for alu_result_collector (WIDTH=8): directed scenarios plus a
// randomized run checked against a queue-based reference model.
module tb_alu_result_collector;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 4;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_bit;
    logic          in_ready;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [CW-1:0] out_count;
`ifdef ALU_COLLECT_PARITY_EN
    logic          out_parity;
`endif

    int checks;
    int failures;

    // Reference model: pending bits as a queue, plus the word being offered.
    int           m_bits[$];
    bit           m_hold;
    logic [W-1:0] m_word;
    int           m_count;
    int           m_words;

    alu_result_collector #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
`ifdef ALU_COLLECT_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the reference model by one clock edge using the driven inputs.
    task automatic model_edge();
        logic [W-1:0] w;
        if (rst) begin
            m_bits.delete();
            m_hold = 1'b0;
        end else if (!m_hold) begin
            if (in_valid) m_bits.push_back(int'(in_bit));
            if (m_bits.size() == W || (flush && m_bits.size() > 0)) begin
                w = '0;
                for (int i = 0; i < m_bits.size(); i++)
                    if (m_bits[i] != 0) w = w + (W'(1) << i);
                m_word  = w;
                m_count = m_bits.size();
                m_hold  = 1'b1;
                m_bits.delete();
            end
        end else if (out_ready) begin
            m_hold  = 1'b0;
            m_words = m_words + 1;
        end
    endtask

    // One clock: model follows the edge, outputs are then sampled at negedge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 1'b0; in_valid = 1'b0; in_bit = 1'b0; flush = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        cycle();
        cycle();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'h00 || out_count !== 4'd0) begin
            failures++;
            $display("FAIL reset: valid=%b ready=%b data=%h count=%0d, want 0 1 00 0",
                     out_valid, in_ready, out_data, out_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_full_word();
        logic [7:0] pat;
        pat = 8'b0100_1101;
        idle_inputs();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_bit = pat[i];
            cycle();
            if (i < 7) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL full_word_early: bit %0d valid=%b want 0", i, out_valid);
                end
            end
        end
        // Upstream keeps offering while the word is held: must be ignored.
        in_bit = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 8'h4D || out_count !== 4'd8) begin
                failures++;
                $display("FAIL full_word_hold: k=%0d valid=%b ready=%b data=%h count=%0d, want 1 0 4d 8",
                         k, out_valid, in_ready, out_data, out_count);
            end
`ifdef ALU_COLLECT_PARITY_EN
            checks++;
            if (out_parity !== 1'b0) begin
                failures++;
                $display("FAIL parity_4d: got %b want 0", out_parity);
            end
`endif
            cycle();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL full_word_release: valid=%b ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_flush();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_bit = 1'b1;
            cycle();
        end
        in_valid = 1'b0; flush = 1'b1;
        cycle();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h07 || out_count !== 4'd3) begin
            failures++;
            $display("FAIL flush_partial: valid=%b data=%h count=%0d want 1 07 3",
                     out_valid, out_data, out_count);
        end
`ifdef ALU_COLLECT_PARITY_EN
        checks++;
        if (out_parity !== 1'b1) begin
            failures++;
            $display("FAIL parity_07: got %b want 1", out_parity);
        end
`endif
        // Flush kept high through HOLD and release must not create a new word.
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        cycle();
        cycle();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_empty: valid=%b ready=%b want 0 1", out_valid, in_ready);
        end
        flush = 1'b0;
    endtask

    task automatic test_flush_same_cycle();
        idle_inputs();
        in_valid = 1'b1; in_bit = 1'b0;
        cycle();
        cycle();
        in_bit = 1'b1; flush = 1'b1;
        cycle();
        in_valid = 1'b0; flush = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h04 || out_count !== 4'd3) begin
            failures++;
            $display("FAIL flush_same_cycle: valid=%b data=%h count=%0d want 1 04 3",
                     out_valid, out_data, out_count);
        end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_word();
        int seen;
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_bit = 1'($urandom);
            cycle();
        end
        in_valid = 1'b0; rst = 1'b1;
        cycle();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_count !== 4'd0 || out_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_mid: valid=%b data=%h count=%0d want 0 00 0",
                     out_valid, out_data, out_count);
        end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_bit = 1'b1;
            cycle();
            if (out_valid === 1'b1) seen++;
        end
        in_valid = 1'b0;
        checks++;
        if (seen !== 1 || out_data !== 8'hFF || out_count !== 4'd8) begin
            failures++;
            $display("FAIL reset_then_full: valid_cycles=%0d data=%h count=%0d want 1 ff 8",
                     seen, out_data, out_count);
        end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int low_cycles;
        int words;
        int low_ok;
        idle_inputs();
        low_cycles = 0; words = 0; low_ok = 1;
        in_valid = 1'b1; out_ready = 1'b1;
        // Word completes after 8 accepts; HOLD lasts one cycle; repeat.
        for (int c = 1; c <= 18; c++) begin
            in_bit = 1'($urandom);
            cycle();
            if (in_ready === 1'b0) low_cycles++;
            if (out_valid === 1'b1) words++;
            if ((in_ready === 1'b0) != (c == 8 || c == 17)) low_ok = 0;
        end
        in_valid = 1'b0;
        cycle();
        out_ready = 1'b0;
        checks++;
        if (words !== 2 || low_cycles !== 2 || low_ok !== 1) begin
            failures++;
            $display("FAIL back_to_back: words=%0d ready_low=%0d pattern_ok=%0d want 2 2 1",
                     words, low_cycles, low_ok);
        end
    endtask

    task automatic test_random();
        idle_inputs();
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(199) == 0);
            in_valid  = ($urandom_range(3) != 0);
            in_bit    = 1'($urandom);
            flush     = ($urandom_range(11) == 0);
            out_ready = ($urandom_range(2) != 0);
            cycle();
            checks++;
            if (out_valid !== m_hold || in_ready !== !m_hold) begin
                failures++;
                $display("FAIL random_handshake: cyc=%0d valid=%b ready=%b want %b %b",
                         c, out_valid, in_ready, m_hold, !m_hold);
            end
            if (m_hold) begin
                checks++;
                if (out_data !== m_word || out_count !== CW'(m_count)) begin
                    failures++;
                    $display("FAIL random_word: cyc=%0d data=%h count=%0d want %h %0d",
                             c, out_data, out_count, m_word, m_count);
                end
`ifdef ALU_COLLECT_PARITY_EN
                checks++;
                if (out_parity !== ^m_word) begin
                    failures++;
                    $display("FAIL random_parity: cyc=%0d got %b want %b", c, out_parity, ^m_word);
                end
`endif
            end
        end
        idle_inputs();
    endtask

    initial begin
        checks = 0; failures = 0;
        m_hold = 1'b0; m_word = '0; m_count = 0; m_words = 0;
        idle_inputs();
        test_reset();
        test_full_word();
        test_flush();
        test_flush_same_cycle();
        test_reset_mid_word();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
